// File: rtl/conv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_pkg : shared types and constants for the conv scheduler      |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package conv_pkg;

    localparam int ANS_W     = 32;
    localparam int PIXEL_W   = 8;
    localparam int PIXEL_MAX = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_OUTPUT  = 3'd5,
        ST_DONE    = 3'd6
    } conv_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_window_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_window_scheduler_if : window request, datapath and pixel bus |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
interface conv_window_scheduler_if #(
    parameter int CW = 10
) ();
    import conv_pkg::*;

    logic                    win_req;
    logic [CW-1:0]           win_x;
    logic [CW-1:0]           win_y;
    logic                    win_ack;
    logic                    conv_load;
    logic signed [ANS_W-1:0] conv_ans;
    logic                    out_valid;
    logic                    out_ready;
    logic [PIXEL_W-1:0]      out_data;
    logic [CW-1:0]           out_x;
    logic [CW-1:0]           out_y;

    modport master (
        output win_req, win_x, win_y, conv_load, out_valid, out_data, out_x, out_y,
        input  win_ack, conv_ans, out_ready
    );

    modport slave (
        input  win_req, win_x, win_y, conv_load, out_valid, out_data, out_x, out_y,
        output win_ack, conv_ans, out_ready
    );

endinterface
`default_nettype wire

// File: rtl/conv_window_scheduler_sat_clip.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_clip : signed result -> arithmetic shift -> clip to 0..255    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module sat_clip
    import conv_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int ANS_W = 32
) (
    input  logic signed [ANS_W-1:0] ans_i,
    output logic [PIXEL_W-1:0]      pix_o
);

    logic signed [ANS_W-1:0] w_shifted;

    assign w_shifted = ans_i >>> SHIFT;

    // Any set bit above the pixel field on a positive value means > PIXEL_MAX.
    always_comb begin
        pix_o = w_shifted[PIXEL_W-1:0];
        if (w_shifted[ANS_W-1]) begin
            pix_o = '0;
        end else if (|w_shifted[ANS_W-2:PIXEL_W]) begin
            pix_o = PIXEL_W'(PIXEL_MAX);
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_window_scheduler : raster-walks valid windows, drives the    |
// | conv datapath and streams clipped pixels.              rev 1.0    |
// +------------------------------------------------------------------+
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int KERNEL_SIZE = 3,
    parameter int SHIFT       = 0,
    parameter int CW          = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    conv_window_scheduler_if.master bus
);

    localparam logic [CW-1:0] X_LAST = CW'(IMG_W - KERNEL_SIZE);
    localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - KERNEL_SIZE);

    conv_sched_state_t  state_q;
    logic               busy_q;
    logic               done_q;
    logic               win_req_q;
    logic               conv_load_q;
    logic               out_valid_q;
    logic [CW-1:0]      x_q;
    logic [CW-1:0]      y_q;
    logic [CW-1:0]      out_x_q;
    logic [CW-1:0]      out_y_q;
    logic [PIXEL_W-1:0] out_data_q;
    logic [PIXEL_W-1:0] pix_d;

    sat_clip #(
        .SHIFT (SHIFT),
        .ANS_W (ANS_W)
    ) u_sat_clip (
        .ans_i (bus.conv_ans),
        .pix_o (pix_d)
    );

    // Every output is a register set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_req_q   <= 1'b0;
            conv_load_q <= 1'b0;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_data_q  <= '0;
        end else begin
            win_req_q   <= 1'b0;
            conv_load_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_FETCH;
                        busy_q    <= 1'b1;
                        win_req_q <= 1'b1;
                        x_q       <= '0;
                        y_q       <= '0;
                    end
                end
                ST_FETCH: begin
                    if (bus.win_ack) begin
                        state_q     <= ST_LOAD;
                        conv_load_q <= 1'b1;
                    end else begin
                        win_req_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_q     <= ST_OUTPUT;
                    out_data_q  <= pix_d;
                    out_x_q     <= x_q;
                    out_y_q     <= y_q;
                    out_valid_q <= 1'b1;
                end
                ST_OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (x_q == X_LAST && y_q == Y_LAST) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_FETCH;
                            win_req_q <= 1'b1;
                            if (x_q == X_LAST) begin
                                x_q <= '0;
                                y_q <= y_q + CW'(1);
                            end else begin
                                x_q <= x_q + CW'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.win_req   = win_req_q;
    assign bus.win_x     = x_q;
    assign bus.win_y     = y_q;
    assign bus.conv_load = conv_load_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;

endmodule
`default_nettype wire
